x_serializer: RTL and testbench

X_SERIALIZER -- requirements
Module: x_serializer

---
 rtl/x_serializer.sv | 118 +++++++++++
 tb/tb_x_serializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_serializer.sv
`default_nettype none
// ============================================================================
// Module      : x_serializer
// Description : Frame serializer. Emits a start strobe, then the payload
//               LSB first, then a one-cycle done pulse carrying the popcount.
// Revision    : 1.0 - initial release
// ============================================================================
module x_serializer #(
    parameter int W  = 16,
    parameter int LW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [W-1:0]  load_data,
    input  logic [LW-1:0] load_len,
    output logic          load_ready,
    output logic          S,
    output logic          X,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] exp_ones
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [LW-1:0] c_max_len = LW'(W);

    state_t        r_state;
    logic [W-1:0]  r_shift;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_ones;
    logic          r_s;
    logic          r_x;
    logic          r_busy;
    logic          r_done;
    logic          r_ready;

    state_t        w_state_nxt;
    logic [W-1:0]  w_shift_nxt;
    logic [LW-1:0] w_len_nxt;
    logic [LW-1:0] w_ones_nxt;
    logic [LW-1:0] w_eff_len;

    assign w_eff_len = (load_len > c_max_len) ? c_max_len : load_len;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_len_nxt   = r_len;
        w_ones_nxt  = r_ones;
        case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_shift_nxt = load_data;
                    w_len_nxt   = w_eff_len;
                    w_ones_nxt  = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_state_nxt = (r_len != '0) ? SHIFT : GAP;
            end
            SHIFT: begin
                w_ones_nxt  = r_ones + {{(LW-1){1'b0}}, r_shift[0]};
                w_shift_nxt = {1'b0, r_shift[W-1:1]};
                w_len_nxt   = r_len - LW'(1);
                w_state_nxt = (r_len == LW'(1)) ? GAP : SHIFT;
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so each lands in the
    // same cycle as the state it belongs to; X tracks the post-shift LSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_len   <= '0;
            r_ones  <= '0;
            r_s     <= 1'b0;
            r_x     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_len   <= w_len_nxt;
            r_ones  <= w_ones_nxt;
            r_s     <= (w_state_nxt == START);
            r_x     <= (w_state_nxt == SHIFT) & w_shift_nxt[0];
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == GAP);
            r_ready <= (w_state_nxt == IDLE);
        end
    end

    assign load_ready = r_ready;
    assign S          = r_s;
    assign X          = r_x;
    assign busy       = r_busy;
    assign done       = r_done;
    assign exp_ones   = r_ones;

endmodule
`default_nettype wire

// File: tb/tb_x_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_x_serializer
// Description : Self-checking bench: per-cycle frame model plus directed
//               literal checks and a downstream one-counter stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x_serializer;

    localparam int W  = 16;
    localparam int LW = $clog2(W) + 1;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          load_valid = 1'b0;
    logic [W-1:0]  load_data  = '0;
    logic [LW-1:0] load_len   = '0;
    logic          load_ready;
    logic          S;
    logic          X;
    logic          busy;
    logic          done;
    logic [LW-1:0] exp_ones;

    int vectors = 0;
    int errors  = 0;

    x_serializer #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_ready (load_ready),
        .S          (S),
        .X          (X),
        .busy       (busy),
        .done       (done),
        .exp_ones   (exp_ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one expected-output record per cycle, queued at accept time.
    typedef struct packed {
        logic          s, x, bsy, dn, rdy, chk_ones;
        logic [LW-1:0] ones;
    } exp_t;

    function automatic exp_t mk(logic s, logic x, logic bsy, logic dn, logic rdy,
                                logic c, logic [LW-1:0] o);
        exp_t e;
        e.s = s; e.x = x; e.bsy = bsy; e.dn = dn; e.rdy = rdy; e.chk_ones = c; e.ones = o;
        return e;
    endfunction

    exp_t          q[$];
    exp_t          cur;
    logic [LW-1:0] last_ones;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            last_ones <= '0;
            cur       <= mk(0, 0, 0, 0, 1, 1, '0);
        end else begin
            if (cur.rdy && load_valid) begin
                int n;
                int pc;
                n  = (int'(load_len) > W) ? W : int'(load_len);
                pc = 0;
                q.push_back(mk(1, 0, 1, 0, 0, 1, '0));
                for (int i = 0; i < n; i++) begin
                    q.push_back(mk(0, load_data[i], 1, 0, 0, 0, '0));
                    pc = pc + int'(load_data[i]);
                end
                q.push_back(mk(0, 0, 1, 1, 0, 1, LW'(pc)));
                last_ones <= LW'(pc);
            end
            if (q.size() > 0) cur <= q.pop_front();
            else              cur <= mk(0, 0, 0, 0, 1, 1, last_ones);
        end
    end

    always @(negedge clk) begin
        chk("S", 32'(S), 32'(cur.s));
        chk("X", 32'(X), 32'(cur.x));
        chk("busy", 32'(busy), 32'(cur.bsy));
        chk("done", 32'(done), 32'(cur.dn));
        chk("load_ready", 32'(load_ready), 32'(cur.rdy));
        if (cur.chk_ones) chk("exp_ones", 32'(exp_ones), 32'(cur.ones));
    end

    // Frame monitor used by the literal checks.
    int            cyc = 0, ns = 0, ndone = 0, nx = 0, xones = 0;
    logic [W-1:0]  xbits = '0;
    int            s_cyc[32], dn_cyc[32], dn_xones[32];
    logic [W-1:0]  dn_bits[32];
    logic [LW-1:0] dn_ones[32];

    always @(negedge clk) begin
        if (reset) begin
            cyc <= cyc + 1;
            if (S) begin
                s_cyc[ns] <= cyc;
                ns        <= ns + 1;
                xbits     <= '0;
                nx        <= 0;
                xones     <= 0;
            end else if (busy && !done) begin
                xbits[nx] <= X;
                nx        <= nx + 1;
                xones     <= xones + int'(X);
            end
            if (done) begin
                dn_cyc[ndone]   <= cyc;
                dn_bits[ndone]  <= xbits;
                dn_xones[ndone] <= xones;
                dn_ones[ndone]  <= exp_ones;
                ndone           <= ndone + 1;
            end
        end
    end

    // Downstream ASM one-counter: cleared by S, counts X ones, G on done.
    logic [3:0] cnt = '0;
    logic       G   = 1'b0;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            G   <= 1'b0;
        end else if (S) begin
            cnt <= '0;
            G   <= 1'b0;
        end else begin
            if (X)    cnt <= cnt + 4'd1;
            if (done) G   <= 1'b1;
        end
    end

    task automatic wait_ndone(input int target, input string name);
        for (int i = 0; i < 200; i++) begin
            if (ndone >= target) break;
            @(negedge clk);
            #1;
        end
        if (ndone < target) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout: got %0d done pulses, expected %0d", name, ndone, target);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic [LW-1:0] l,
                        input string name, output int idx);
        idx = ndone;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_len   = l;
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = ~d;
        load_len   = ~l;
        wait_ndone(idx + 1, name);
    endtask

    initial begin
        int idx;
        int nd0;
        #1 reset = 1'b0;
        #3;
        chk("rst_S", 32'(S), 0);
        chk("rst_X", 32'(X), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ones", 32'(exp_ones), 0);
        chk("rst_ready", 32'(load_ready), 1);
        @(negedge clk);
        reset = 1'b1;

        send(16'h00A5, 5'd8, "basic", idx);
        chk("basic_done_lat", 32'(dn_cyc[idx] - s_cyc[ns-1]), 9);
        chk("basic_bits", 32'(dn_bits[idx][7:0]), 32'h00A5);
        chk("basic_ones", 32'(dn_ones[idx]), 4);
        @(negedge clk);
        #1 chk("basic_ready_after", 32'(load_ready), 1);

        send(16'hFFFF, 5'd0, "zero", idx);
        chk("zero_done_lat", 32'(dn_cyc[idx] - s_cyc[ns-1]), 1);
        chk("zero_xones", 32'(dn_xones[idx]), 0);
        chk("zero_ones", 32'(dn_ones[idx]), 0);

        send(16'hFFFF, 5'd31, "sat", idx);
        chk("sat_done_lat", 32'(dn_cyc[idx] - s_cyc[ns-1]), 17);
        chk("sat_xones", 32'(dn_xones[idx]), 16);
        chk("sat_ones", 32'(dn_ones[idx]), 16);

        // Held valid with data changing every cycle.
        idx = ndone;
        @(negedge clk);
        load_valid = 1'b1;
        load_len   = 5'd4;
        for (int i = 0; i < 12; i++) begin
            load_data = 16'h000B ^ 16'(i * 37);
            @(negedge clk);
        end
        load_valid = 1'b0;
        wait_ndone(idx + 2, "held");
        chk("held_period", 32'(s_cyc[ns-1] - s_cyc[ns-2]), 7);
        chk("held_first_bits", 32'(dn_bits[idx][3:0]), 32'hB);
        chk("held_second_bits", 32'(dn_bits[idx+1][3:0]), 32'((16'h000B ^ 16'(7 * 37)) & 16'hF));

        // Reset during bit 3 of a 10-bit frame.
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 16'h03FF;
        load_len   = 5'd10;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("mid_busy", 32'(busy), 1);
        chk("mid_bit3", 32'(X), 1);
        #1 reset = 1'b0;
        #1;
        chk("abort_S", 32'(S), 0);
        chk("abort_X", 32'(X), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ones", 32'(exp_ones), 0);
        chk("abort_ready", 32'(load_ready), 1);
        nd0 = ndone;
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        #1 chk("abort_no_done", 32'(ndone), 32'(nd0));

        // Downstream counter stage.
        send(16'hFFFF, 5'd15, "link", idx);
        @(negedge clk);
        #1;
        chk("link_cnt", 32'(cnt), 32'hF);
        chk("link_G", 32'(G), 1);
        chk("link_ones", 32'(dn_ones[idx]), 15);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
